alu_unit: RTL

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_unit.sv
// alu_unit: single-cycle RV32I-style ALU behind a two-state request/ready
// handshake. Accepts a one-hot decoded instruction, computes the result at the
// accepting edge and holds it (with ready) until the request is withdrawn.
module alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ALUenable,
  input  logic [36:0] ALU_instr_bus,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [31:0] ALUoutput,
  output logic        ALUready,
  output logic        ALUerror
);

  // Instruction bit positions on ALU_instr_bus.
  localparam int unsigned OP_LUI   = 0;
  localparam int unsigned OP_AUIPC = 1;
  localparam int unsigned OP_ADDI  = 2;
  localparam int unsigned OP_SLTI  = 3;
  localparam int unsigned OP_SLTIU = 4;
  localparam int unsigned OP_XORI  = 5;
  localparam int unsigned OP_ORI   = 6;
  localparam int unsigned OP_ANDI  = 7;
  localparam int unsigned OP_SLLI  = 8;
  localparam int unsigned OP_SRLI  = 9;
  localparam int unsigned OP_SRAI  = 10;
  localparam int unsigned OP_ADD   = 11;
  localparam int unsigned OP_SUB   = 12;
  localparam int unsigned OP_SLL   = 13;
  localparam int unsigned OP_SLT   = 14;
  localparam int unsigned OP_SLTU  = 15;
  localparam int unsigned OP_XOR   = 16;
  localparam int unsigned OP_SRL   = 17;
  localparam int unsigned OP_SRA   = 18;
  localparam int unsigned OP_OR    = 19;
  localparam int unsigned OP_AND   = 20;
  localparam int unsigned OP_LB    = 21;
  localparam int unsigned OP_LH    = 22;
  localparam int unsigned OP_LW    = 23;
  localparam int unsigned OP_LBU   = 24;
  localparam int unsigned OP_LHU   = 25;
  localparam int unsigned OP_SB    = 26;
  localparam int unsigned OP_BEQ   = 27;
  localparam int unsigned OP_BNE   = 28;
  localparam int unsigned OP_BLT   = 29;
  localparam int unsigned OP_BGE   = 30;
  localparam int unsigned OP_BLTU  = 31;
  localparam int unsigned OP_BGEU  = 32;
  localparam int unsigned OP_JAL   = 33;
  localparam int unsigned OP_JALR  = 34;
  localparam int unsigned OP_SH    = 35;
  localparam int unsigned OP_SW    = 36;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // True when exactly one bit of the decoded instruction is set.
  function automatic logic is_one_hot(input logic [36:0] vec);
    return (vec != 37'd0) && ((vec & (vec - 37'd1)) == 37'd0);
  endfunction

  // Zero-extend a single comparison bit to a 32-bit result.
  function automatic logic [31:0] flag32(input logic flag);
    return {31'd0, flag};
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] out_next_s;
  logic        ready_next_s;
  logic        err_next_s;

  logic        legal_s;
  logic [31:0] result_s;

  // Shared datapath terms.
  logic [31:0] sum_imm_s;
  logic [31:0] sum_rs2_s;
  logic [31:0] diff_s;
  logic [31:0] link_s;
  logic [31:0] auipc_s;
  logic [4:0]  shamt_imm_s;
  logic [4:0]  shamt_rs2_s;
  logic        lt_s_imm_s;
  logic        lt_u_imm_s;
  logic        lt_s_rs2_s;
  logic        lt_u_rs2_s;
  logic        eq_rs2_s;

  assign legal_s     = is_one_hot(ALU_instr_bus);
  assign sum_imm_s   = rs1_value + imm;
  assign sum_rs2_s   = rs1_value + rs2_value;
  assign diff_s      = rs1_value - rs2_value;
  assign link_s      = pc + 32'd4;
  assign auipc_s     = pc + imm;
  assign shamt_imm_s = imm[4:0];
  assign shamt_rs2_s = rs2_value[4:0];
  assign lt_s_imm_s  = $signed(rs1_value) < $signed(imm);
  assign lt_u_imm_s  = rs1_value < imm;
  assign lt_s_rs2_s  = $signed(rs1_value) < $signed(rs2_value);
  assign lt_u_rs2_s  = rs1_value < rs2_value;
  assign eq_rs2_s    = rs1_value == rs2_value;

  // Select the result of the instruction whose bit is set on the bus.
  always_comb begin
    result_s = 32'd0;
    case (1'b1)
      ALU_instr_bus[OP_LUI]:   result_s = imm;
      ALU_instr_bus[OP_AUIPC]: result_s = auipc_s;
      ALU_instr_bus[OP_ADDI]:  result_s = sum_imm_s;
      ALU_instr_bus[OP_SLTI]:  result_s = flag32(lt_s_imm_s);
      ALU_instr_bus[OP_SLTIU]: result_s = flag32(lt_u_imm_s);
      ALU_instr_bus[OP_XORI]:  result_s = rs1_value ^ imm;
      ALU_instr_bus[OP_ORI]:   result_s = rs1_value | imm;
      ALU_instr_bus[OP_ANDI]:  result_s = rs1_value & imm;
      ALU_instr_bus[OP_SLLI]:  result_s = rs1_value << shamt_imm_s;
      ALU_instr_bus[OP_SRLI]:  result_s = rs1_value >> shamt_imm_s;
      ALU_instr_bus[OP_SRAI]:  result_s = $unsigned($signed(rs1_value) >>> shamt_imm_s);
      ALU_instr_bus[OP_ADD]:   result_s = sum_rs2_s;
      ALU_instr_bus[OP_SUB]:   result_s = diff_s;
      ALU_instr_bus[OP_SLL]:   result_s = rs1_value << shamt_rs2_s;
      ALU_instr_bus[OP_SLT]:   result_s = flag32(lt_s_rs2_s);
      ALU_instr_bus[OP_SLTU]:  result_s = flag32(lt_u_rs2_s);
      ALU_instr_bus[OP_XOR]:   result_s = rs1_value ^ rs2_value;
      ALU_instr_bus[OP_SRL]:   result_s = rs1_value >> shamt_rs2_s;
      ALU_instr_bus[OP_SRA]:   result_s = $unsigned($signed(rs1_value) >>> shamt_rs2_s);
      ALU_instr_bus[OP_OR]:    result_s = rs1_value | rs2_value;
      ALU_instr_bus[OP_AND]:   result_s = rs1_value & rs2_value;
      ALU_instr_bus[OP_LB],
      ALU_instr_bus[OP_LH],
      ALU_instr_bus[OP_LW],
      ALU_instr_bus[OP_LBU],
      ALU_instr_bus[OP_LHU],
      ALU_instr_bus[OP_SB],
      ALU_instr_bus[OP_SH],
      ALU_instr_bus[OP_SW]:    result_s = sum_imm_s;
      ALU_instr_bus[OP_BEQ]:   result_s = flag32(eq_rs2_s);
      ALU_instr_bus[OP_BNE]:   result_s = flag32(!eq_rs2_s);
      ALU_instr_bus[OP_BLT]:   result_s = flag32(lt_s_rs2_s);
      ALU_instr_bus[OP_BGE]:   result_s = flag32(!lt_s_rs2_s);
      ALU_instr_bus[OP_BLTU]:  result_s = flag32(lt_u_rs2_s);
      ALU_instr_bus[OP_BGEU]:  result_s = flag32(!lt_u_rs2_s);
      ALU_instr_bus[OP_JAL],
      ALU_instr_bus[OP_JALR]:  result_s = link_s;
      default:                 result_s = 32'd0;
    endcase
  end

  // Handshake next-state logic: accept in IDLE, freeze everything in DONE.
  always_comb begin
    next_state_s = state_r;
    out_next_s   = ALUoutput;
    ready_next_s = 1'b0;
    err_next_s   = ALUerror;
    case (state_r)
      ST_IDLE: begin
        if (ALUenable) begin
          next_state_s = ST_DONE;
          out_next_s   = legal_s ? result_s : 32'd0;
          ready_next_s = 1'b1;
          err_next_s   = !legal_s;
        end else begin
          next_state_s = ST_IDLE;
          ready_next_s = 1'b0;
        end
      end
      ST_DONE: begin
        if (ALUenable) begin
          next_state_s = ST_DONE;
          ready_next_s = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
          ready_next_s = 1'b0;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        ready_next_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any handshake in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ALUoutput <= 32'd0;
      ALUready  <= 1'b0;
      ALUerror  <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      ALUoutput <= out_next_s;
      ALUready  <= ready_next_s;
      ALUerror  <= err_next_s;
    end
  end

endmodule
